// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter.
// Port indices, starvation bound and write-protect window defaults.
package dmem_arb_pkg;

    localparam int PORT_C = 0;
    localparam int PORT_A = 1;

    localparam int          MAX_WAIT_DEF = 4;
    localparam logic [31:0] WPROT_LO_DEF = 32'h80;
    localparam logic [31:0] WPROT_HI_DEF = 32'hBC;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bundle of the data-memory arbiter.
// master = requesters plus memory, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              a_werr;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata, a_werr,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata, a_werr,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_arb_rdreg.sv
// Per-port read-data register: captures memory data on a granted read
// and pulses rvalid for the following cycle.
module dmem_arb_rdreg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= cap;
            if (cap) begin
                rdata <= din;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU priority with a starvation guard for aux.
// Optional aux write-protect window enabled by DMEM_ARB_WPROT_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                MAX_WAIT = MAX_WAIT_DEF,
    parameter logic [ADDR_W-1:0] WPROT_LO = ADDR_W'(WPROT_LO_DEF),
    parameter logic [ADDR_W-1:0] WPROT_HI = ADDR_W'(WPROT_HI_DEF)
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    logic [7:0] wcnt;
    logic       force_a;
    logic       a_gnt;
    logic       c_gnt;
    logic       a_prot;
    logic [1:0] cap;

    assign force_a = (wcnt == 8'(MAX_WAIT));
    assign a_gnt   = reset & bus.a_req & (~bus.c_req | force_a);
    assign c_gnt   = reset & bus.c_req & ~a_gnt;

    assign bus.a_gnt = a_gnt;
    assign bus.c_gnt = c_gnt;

`ifdef DMEM_ARB_WPROT_EN
    logic werr;

    assign a_prot = bus.a_we
                  & (bus.a_addr >= WPROT_LO)
                  & (bus.a_addr <= WPROT_HI);

    always_ff @(posedge clk) begin
        if (!reset) begin
            werr <= 1'b0;
        end else begin
            werr <= a_gnt & a_prot;
        end
    end

    assign bus.a_werr = werr;
`else
    logic unused_prot;

    assign a_prot      = 1'b0;
    assign unused_prot = ^{WPROT_LO, WPROT_HI};
    assign bus.a_werr  = 1'b0;
`endif

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (1'b1)
            c_gnt: begin
                bus.mem_read  = ~bus.c_we;
                bus.mem_write = bus.c_we;
                bus.mem_addr  = bus.c_addr;
                bus.mem_wdata = bus.c_wdata;
            end
            a_gnt: begin
                bus.mem_read  = ~bus.a_we;
                bus.mem_write = bus.a_we & ~a_prot;
                bus.mem_addr  = bus.a_addr;
                bus.mem_wdata = bus.a_wdata;
            end
            default: ;
        endcase
    end

    // Refused aux cycles; reaching MAX_WAIT forces aux through next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wcnt <= '0;
        end else if (!bus.a_req || a_gnt) begin
            wcnt <= '0;
        end else if (!force_a) begin
            wcnt <= wcnt + 8'd1;
        end
    end

    assign cap[PORT_C] = c_gnt & ~bus.c_we;
    assign cap[PORT_A] = a_gnt & ~bus.a_we;

    dmem_arb_rdreg #(.DATA_W(DATA_W)) u_rd_c (
        .clk    (clk),
        .reset  (reset),
        .cap    (cap[PORT_C]),
        .din    (bus.mem_rdata),
        .rdata  (bus.c_rdata),
        .rvalid (bus.c_rvalid)
    );

    dmem_arb_rdreg #(.DATA_W(DATA_W)) u_rd_a (
        .clk    (clk),
        .reset  (reset),
        .cap    (cap[PORT_A]),
        .din    (bus.mem_rdata),
        .rdata  (bus.a_rdata),
        .rvalid (bus.a_rvalid)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, read-data scoreboard, directed cases.
// Build with DMEM_ARB_WPROT_EN to exercise the write-protect window.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit prot_model(input logic we, input logic [31:0] addr);
`ifdef DMEM_ARB_WPROT_EN
        return we && addr >= 32'h80 && addr <= 32'hBC;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: push expected read data on a grant, pop on rvalid.
    logic [31:0] cq[$];
    logic [31:0] aq[$];
    bit c_pend = 0, a_pend = 0, w_pend = 0, started = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("c_rvalid", {31'b0, bus.c_rvalid}, {31'b0, c_pend});
            chk("a_rvalid", {31'b0, bus.a_rvalid}, {31'b0, a_pend});
            chk("a_werr", {31'b0, bus.a_werr}, {31'b0, w_pend});
            if (bus.c_rvalid) begin
                if (cq.size() == 0) chk("c_q_underflow", 32'd1, 32'd0);
                else chk("c_rdata", bus.c_rdata, cq.pop_front());
            end
            if (bus.a_rvalid) begin
                if (aq.size() == 0) chk("a_q_underflow", 32'd1, 32'd0);
                else chk("a_rdata", bus.a_rdata, aq.pop_front());
            end
            c_pend = bus.c_gnt && !bus.c_we;
            a_pend = bus.a_gnt && !bus.a_we;
            w_pend = bus.a_gnt && prot_model(bus.a_we, bus.a_addr);
            if (c_pend) cq.push_back(ref_mem[bus.c_addr[7:2]]);
            if (a_pend) aq.push_back(ref_mem[bus.a_addr[7:2]]);
            if (bus.c_gnt && bus.c_we) ref_mem[bus.c_addr[7:2]] = bus.c_wdata;
            if (bus.a_gnt && bus.a_we && !prot_model(bus.a_we, bus.a_addr))
                ref_mem[bus.a_addr[7:2]] = bus.a_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    endtask

    task automatic c_drive(input logic we, input logic [31:0] addr,
                           input logic [31:0] wd);
        bus.c_req = 1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
    endtask

    task automatic a_drive(input logic we, input logic [31:0] addr,
                           input logic [31:0] wd);
        bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic chk_gnt(input string tag, input bit c, input bit a);
        chk({tag, "_c_gnt"}, {31'b0, bus.c_gnt}, {31'b0, c});
        chk({tag, "_a_gnt"}, {31'b0, bus.a_gnt}, {31'b0, a});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h5A000000 + 32'(i);
            ref_mem[i] = 32'h5A000000 + 32'(i);
        end
        mem[32] = 32'h3F;   ref_mem[32] = 32'h3F;
        mem[33] = 32'h1111; ref_mem[33] = 32'h1111;

        // Reset with both requesting writes.
        reset = 0;
        idle();
        c_drive(1, 32'h10, 32'hDEAD);
        a_drive(1, 32'h40, 32'hBEEF);
        @(posedge clk);
        #1;
        started = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_gnt("rst", 0, 0);
            chk("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
            chk("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
            step();
        end
        chk("rst_c_rdata", bus.c_rdata, 32'd0);
        chk("rst_a_rdata", bus.a_rdata, 32'd0);
        chk("rst_wcnt", {24'b0, dut.wcnt}, 32'd0);
        reset = 1;
        idle();
        @(negedge clk);
        chk("idle_mem_read", {31'b0, bus.mem_read}, 32'd0);
        chk("idle_mem_addr", bus.mem_addr, 32'd0);
        step();

        // CPU alone: write then read back.
        c_drive(1, 32'h10, 32'h1234);
        @(negedge clk);
        chk_gnt("cw", 1, 0);
        chk("cw_mem_write", {31'b0, bus.mem_write}, 32'd1);
        chk("cw_mem_addr", bus.mem_addr, 32'h10);
        chk("cw_mem_wdata", bus.mem_wdata, 32'h1234);
        step();
        c_drive(0, 32'h10, 32'h0);
        @(negedge clk);
        chk_gnt("cr", 1, 0);
        chk("cr_mem_read", {31'b0, bus.mem_read}, 32'd1);
        step();
        idle();
        chk("cr_c_rdata", bus.c_rdata, 32'h1234);
        step();
        chk("cr_c_rdata_hold", bus.c_rdata, 32'h1234);

        // Contention: A forced through every MAX_WAIT+1 cycles.
        c_drive(0, 32'h10, 32'h0);
        a_drive(0, 32'h80, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("cont_wcnt", {24'b0, dut.wcnt}, 32'(k % 5));
            chk_gnt("cont", (k % 5) != 4, (k % 5) == 4);
            chk("cont_mem_addr", bus.mem_addr,
                ((k % 5) == 4) ? 32'h80 : 32'h10);
            step();
        end

        // A drops its request while waiting: counter clears.
        idle();
        step();
        c_drive(0, 32'h10, 32'h0);
        a_drive(0, 32'h80, 32'h0);
        step();
        step();
        bus.a_req = 0;
        @(negedge clk);
        chk("drop_wcnt_before", {24'b0, dut.wcnt}, 32'd2);
        step();
        chk("drop_wcnt_after", {24'b0, dut.wcnt}, 32'd0);
        idle();
        step();

        // Aux read alone.
        a_drive(0, 32'h80, 32'h0);
        @(negedge clk);
        chk_gnt("ar", 0, 1);
        step();
        idle();
        chk("ar_a_rdata", bus.a_rdata, 32'h3F);
        chk("ar_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
        step();

        // Reset right after a granted read.
        c_drive(0, 32'h10, 32'h0);
        a_drive(0, 32'h80, 32'h0);
        @(negedge clk);
        chk_gnt("mr", 1, 0);
        step();
        reset = 0;
        idle();
        @(negedge clk);
        chk("mr_wcnt_pre", {24'b0, dut.wcnt}, 32'd1);
        step();
        chk("mr_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
        chk("mr_c_rdata", bus.c_rdata, 32'd0);
        chk("mr_wcnt", {24'b0, dut.wcnt}, 32'd0);
        reset = 1;
        step();

        // Aux write outside the protected window commits.
        a_drive(1, 32'h40, 32'hABCD);
        @(negedge clk);
        chk_gnt("aw", 0, 1);
        chk("aw_mem_write", {31'b0, bus.mem_write}, 32'd1);
        step();
        a_drive(0, 32'h40, 32'h0);
        step();
        idle();
        chk("aw_rd", bus.a_rdata, 32'hABCD);

        // Aux write inside the protected window.
        a_drive(1, 32'h84, 32'hFF);
        @(negedge clk);
        chk_gnt("pw", 0, 1);
`ifdef DMEM_ARB_WPROT_EN
        chk("pw_mem_write", {31'b0, bus.mem_write}, 32'd0);
`else
        chk("pw_mem_write", {31'b0, bus.mem_write}, 32'd1);
`endif
        step();
        a_drive(0, 32'h84, 32'h0);
        step();
        idle();
`ifdef DMEM_ARB_WPROT_EN
        chk("pw_rd", bus.a_rdata, 32'h1111);
`else
        chk("pw_rd", bus.a_rdata, 32'hFF);
`endif

        // CPU write into the window is never blocked.
        c_drive(1, 32'h88, 32'h77);
        @(negedge clk);
        chk("cpw_mem_write", {31'b0, bus.mem_write}, 32'd1);
        step();
        c_drive(0, 32'h88, 32'h0);
        step();
        idle();
        chk("cpw_rd", bus.c_rdata, 32'h77);
        step();
        step();

        chk("c_q_empty", 32'(cq.size()), 32'd0);
        chk("a_q_empty", 32'(aq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
